regwb_trace_fifo: RTL and testbench

Writeback trace buffer sitting directly downstream of the tinyriscv register-file write port.
- Snoops every GPR write (we/addr/data) and filters it against a per-register watch mask.
- Timestamps each accepted write and queues it in a show-ahead FIFO.
- Drains the queue over a valid/ready stream to the trace sink (file dumper or UART bridge).
- Lets benches and on-chip debug log selected registers (e.g. x26/x27) without probing internal hierarchy.

---
 rtl/regwb_trace_fifo.sv | 78 +++++++
 tb/tb_regwb_trace_fifo.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/regwb_trace_fifo.sv
// regwb_trace_fifo: filtered, timestamped register-file writeback trace FIFO
// Define TRACE_DEDUP_EN to suppress writes repeating the last recorded {addr, data}.
module regwb_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int TS_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_we_i,
  input  logic [4:0]         wb_waddr_i,
  input  logic [31:0]        wb_wdata_i,
  input  logic [31:0]        watch_mask_i,
  input  logic               clr_i,
  output logic               trace_valid_o,
  input  logic               trace_ready_i,
  output logic [TS_W+36:0]   trace_data_o,
  output logic [ADDR_W:0]    count_o,
  output logic               overflow_o,
  output logic [15:0]        drop_cnt_o
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  logic [TS_W+36:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [TS_W-1:0]   ts;
  logic              qual, cand, full, push, pop, drop;
  assign qual = wb_we_i && wb_waddr_i != 5'd0 && watch_mask_i[wb_waddr_i];
`ifdef TRACE_DEDUP_EN
  logic        last_vld;
  logic [36:0] last;
  assign cand = qual && !(last_vld && last == {wb_waddr_i, wb_wdata_i});
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      last_vld <= 1'b0;
      last     <= '0;
    end else if (clr_i) begin
      last_vld <= 1'b0;
    end else if (push) begin
      last_vld <= 1'b1;
      last     <= {wb_waddr_i, wb_wdata_i};
    end
`else
  assign cand = qual;
`endif
  assign full          = count_o == FULL_CNT;
  assign trace_valid_o = count_o != '0;
  assign trace_data_o  = trace_valid_o ? mem[rd_ptr] : '0;
  assign pop           = trace_valid_o && trace_ready_i && !clr_i;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push          = cand && !clr_i && (!full || pop);
  assign drop          = cand && !clr_i && full && !pop;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {ts, wb_waddr_i, wb_wdata_i};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ts         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (clr_i) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count_o    <= '0;
        overflow_o <= 1'b0;
        drop_cnt_o <= '0;
      end else begin
        wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
        rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
        count_o    <= push && !pop ? count_o + 1'b1 : pop && !push ? count_o - 1'b1 : count_o;
        overflow_o <= overflow_o | drop;
        drop_cnt_o <= drop && drop_cnt_o != 16'hFFFF ? drop_cnt_o + 1'b1 : drop_cnt_o;
      end
    end
endmodule

// File: tb/tb_regwb_trace_fifo.sv
// tb_regwb_trace_fifo: queue-model bench for regwb_trace_fifo with directed scenarios.
module tb_regwb_trace_fifo;
  localparam int DEPTH = 16;
  localparam int TS_W  = 16;
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              we = 1'b0;
  logic [4:0]        waddr = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       mask = '0;
  logic              clr = 1'b0;
  logic              ready = 1'b0;
  logic              valid;
  logic [TS_W+36:0]  data;
  logic [4:0]        count;
  logic              ovf;
  logic [15:0]       dcnt;
  int                n_chk = 0;
  int                n_fail = 0;

  regwb_trace_fifo #(.DEPTH(DEPTH), .ADDR_W(4), .TS_W(TS_W)) dut (
    .clk(clk), .rst(rst), .wb_we_i(we), .wb_waddr_i(waddr), .wb_wdata_i(wdata),
    .watch_mask_i(mask), .clr_i(clr), .trace_valid_o(valid), .trace_ready_i(ready),
    .trace_data_o(data), .count_o(count), .overflow_o(ovf), .drop_cnt_o(dcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of recorded entries plus scalar statistics.
  logic [TS_W+36:0] q[$];
  logic [TS_W-1:0]  m_ts;
  logic             m_ovf;
  int               m_drop;
  logic             m_lv;
  logic [36:0]      m_last;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_ts = '0; m_ovf = 1'b0; m_drop = 0; m_lv = 1'b0;
    end else begin
      logic rec;
      rec = we && waddr != 0 && mask[waddr];
`ifdef TRACE_DEDUP_EN
      if (m_lv && m_last == {waddr, wdata}) rec = 1'b0;
`endif
      if (clr) begin
        q.delete();
        m_ovf = 1'b0; m_drop = 0; m_lv = 1'b0;
      end else begin
        if (q.size() > 0 && ready) void'(q.pop_front());
        if (rec) begin
          if (q.size() < DEPTH) begin
            q.push_back({m_ts, waddr, wdata});
            m_lv = 1'b1; m_last = {waddr, wdata};
          end else begin
            m_ovf = 1'b1;
            if (m_drop < 16'hFFFF) m_drop++;
          end
        end
      end
      m_ts = m_ts + 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("cyc_valid", 64'(valid), 64'(q.size() > 0));
    chk("cyc_data", 64'(data), q.size() > 0 ? 64'(q[0]) : 64'd0);
    chk("cyc_count", 64'(count), 64'(q.size()));
    chk("cyc_ovf", 64'(ovf), 64'(m_ovf));
    chk("cyc_drop", 64'(dcnt), 64'(m_drop));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    // Scenario 1: timestamp capture and mask filter.
    mask = 32'h0C00_0000;
    rst = 1'b1;
    repeat (5) tick();
    wr(5'd26, 32'h1234);
    chk("t1_valid", 64'(valid), 64'd1);
    chk("t1_data", 64'(data), 64'({16'd5, 5'd26, 32'h1234}));
    wr(5'd5, 32'hDEAD);
    chk("t1_x5_filtered", 64'(count), 64'd1);
    ready = 1'b1; tick(); ready = 1'b0;
    chk("t1_drained", 64'(valid), 64'd0);
    // Scenario 2: overflow with ready held low, then ordered drain.
    for (int i = 0; i < 17; i++) wr(5'd27, 32'(i));
    chk("t2_count", 64'(count), 64'd16);
    chk("t2_ovf", 64'(ovf), 64'd1);
    chk("t2_drop", 64'(dcnt), 64'd1);
    for (int i = 0; i < 16; i++) begin
      chk("t2_order", 64'(data[31:0]), 64'(i));
      ready = 1'b1; tick(); ready = 1'b0;
    end
    chk("t2_empty", 64'(count), 64'd0);
    chk("t2_ovf_sticky", 64'(ovf), 64'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t2_ovf_clr", 64'(ovf), 64'd0);
    chk("t2_drop_clr", 64'(dcnt), 64'd0);
    // Scenario 3: full FIFO with simultaneous pop and write.
    for (int i = 0; i < 16; i++) wr(5'd27, 32'(200 + i));
    chk("t3_full", 64'(count), 64'd16);
    ready = 1'b1; wr(5'd26, 32'd999); ready = 1'b0;
    chk("t3_count", 64'(count), 64'd16);
    chk("t3_drop", 64'(dcnt), 64'd0);
    chk("t3_ovf", 64'(ovf), 64'd0);
    for (int i = 0; i < 16; i++) begin
      chk("t3_order", 64'(data[31:0]), i < 15 ? 64'(201 + i) : 64'd999);
      ready = 1'b1; tick(); ready = 1'b0;
    end
    // Scenario 4: x0 never recorded; clr beats a same-cycle push.
    mask = 32'hFFFF_FFFF;
    wr(5'd0, 32'h55);
    chk("t4_x0", 64'(count), 64'd0);
    wr(5'd3, 32'h1); wr(5'd3, 32'h2);
    chk("t4_pre", 64'(count), 64'd2);
    clr = 1'b1; wr(5'd3, 32'h3); clr = 1'b0;
    chk("t4_clr_count", 64'(count), 64'd0);
    chk("t4_clr_valid", 64'(valid), 64'd0);
    // Scenario 5: asynchronous reset in the middle of a drain.
    for (int i = 0; i < 4; i++) wr(5'd9, 32'(i));
    ready = 1'b1; tick();
    chk("t5_pre", 64'(count), 64'd3);
    #2 rst = 1'b0;
    #1;
    chk("t5_valid", 64'(valid), 64'd0);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_data", 64'(data), 64'd0);
    chk("t5_ts", 64'(dut.ts), 64'd0);
    ready = 1'b0;
    @(negedge clk); rst = 1'b1;
    wr(5'd1, 32'd55);
    chk("t5_ts_restart", 64'(data), 64'({16'd0, 5'd1, 32'd55}));
    ready = 1'b1; tick(); ready = 1'b0;
    // Scenario 6: repeated identical writes.
    clr = 1'b1; tick(); clr = 1'b0;
    wr(5'd26, 32'd7); wr(5'd26, 32'd7); wr(5'd26, 32'd7); wr(5'd26, 32'd8);
`ifdef TRACE_DEDUP_EN
    chk("t6_count", 64'(count), 64'd2);
    chk("t6_first", 64'(data[31:0]), 64'd7);
    ready = 1'b1; tick(); ready = 1'b0;
    chk("t6_second", 64'(data[31:0]), 64'd8);
`else
    chk("t6_count", 64'(count), 64'd4);
`endif
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
